// File: rtl/mc_controller_hs.sv
// rtl/mc_controller_hs.sv - multicycle RV32I controller with memory handshake, bus timeout and traps
module mc_controller_hs #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       N,
    input  logic       Z,
    input  logic       C,
    input  logic       V,
    input  logic       MemReady,
    output logic [2:0] ImmSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic       AdrSrc,
    output logic [3:0] ALUControl,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       MemReq,
    output logic       Trap,
    output logic [1:0] TrapCause
);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_AND   = 4'b0010;
    localparam logic [3:0] ALU_OR    = 4'b0011;
    localparam logic [3:0] ALU_XOR   = 4'b0100;
    localparam logic [3:0] ALU_SLT   = 4'b0101;
    localparam logic [3:0] ALU_SLL   = 4'b0110;
    localparam logic [3:0] ALU_SRL   = 4'b0111;
    localparam logic [3:0] ALU_SRA   = 4'b1000;
    localparam logic [3:0] ALU_SLTU  = 4'b1001;
    localparam logic [3:0] ALU_PASSB = 4'b1010;

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_LUI, S_AUIPC, S_ALUWB, S_BRANCH,
        S_JAL, S_JALR_TGT, S_JALR_LINK, S_FAULT
    } state_t;

    state_t           state;
    state_t           nxt;
    logic [1:0]       nxt_cause;
    logic [CNT_W-1:0] wait_cnt;
    logic             waiting;
    logic             timeout;
    logic             br_legal;
    logic             br_taken;
    logic             mreq_q;
    logic [3:0]       alu_dec;

    always_comb begin
        ImmSrc = 3'b000;
        case (op)
            OP_STORE:         ImmSrc = 3'b001;
            OP_BR:            ImmSrc = 3'b010;
            OP_JAL:           ImmSrc = 3'b011;
            OP_LUI, OP_AUIPC: ImmSrc = 3'b100;
            default:          ImmSrc = 3'b000;
        endcase
    end

    always_comb begin
        alu_dec = ALU_ADD;
        case (funct3)
            3'b000:  alu_dec = (op[5] && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_dec = ALU_SLL;
            3'b010:  alu_dec = ALU_SLT;
            3'b011:  alu_dec = ALU_SLTU;
            3'b100:  alu_dec = ALU_XOR;
            3'b101:  alu_dec = funct7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  alu_dec = ALU_OR;
            default: alu_dec = ALU_AND;
        endcase
    end

    always_comb begin
        br_legal = 1'b1;
        br_taken = 1'b0;
        case (funct3)
            3'b000:  br_taken = Z;
            3'b001:  br_taken = !Z;
            3'b100:  br_taken = N ^ V;
            3'b101:  br_taken = !(N ^ V);
            3'b110:  br_taken = !C;
            3'b111:  br_taken = C;
            default: br_legal = 1'b0;
        endcase
    end

    // MemReady has priority over the timeout in the same cycle
    assign waiting = (state == S_FETCH) || (state == S_MEMREAD) || (state == S_MEMWRITE);
    assign timeout = (TIMEOUT_CYCLES != 0) && waiting && !MemReady && (wait_cnt == TO_LAST);

    always_comb begin
        nxt       = state;
        nxt_cause = TrapCause;
        case (state)
            S_FETCH: begin
                if (MemReady) nxt = S_DECODE;
                else if (timeout) begin
                    nxt       = S_FAULT;
                    nxt_cause = 2'b11;
                end
            end
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: nxt = S_MEMADR;
                    OP_R:              nxt = S_EXECR;
                    OP_I:              nxt = S_EXECI;
                    OP_LUI:            nxt = S_LUI;
                    OP_AUIPC:          nxt = S_AUIPC;
                    OP_BR:             nxt = S_BRANCH;
                    OP_JAL:            nxt = S_JAL;
                    OP_JALR:           nxt = S_JALR_TGT;
                    default: begin
                        nxt       = S_FAULT;
                        nxt_cause = 2'b01;
                    end
                endcase
            end
            S_MEMADR: nxt = op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD: begin
                if (MemReady) nxt = S_MEMWB;
                else if (timeout) begin
                    nxt       = S_FAULT;
                    nxt_cause = 2'b11;
                end
            end
            S_MEMWB: nxt = S_FETCH;
            S_MEMWRITE: begin
                if (MemReady) nxt = S_FETCH;
                else if (timeout) begin
                    nxt       = S_FAULT;
                    nxt_cause = 2'b11;
                end
            end
            S_EXECR, S_EXECI, S_LUI, S_AUIPC: nxt = S_ALUWB;
            S_ALUWB: nxt = S_FETCH;
            S_BRANCH: begin
                if (br_legal) nxt = S_FETCH;
                else begin
                    nxt       = S_FAULT;
                    nxt_cause = 2'b10;
                end
            end
            S_JAL:       nxt = S_ALUWB;
            S_JALR_TGT:  nxt = S_JALR_LINK;
            S_JALR_LINK: nxt = S_ALUWB;
            default:     nxt = S_FAULT;
        endcase
    end

    // Datapath selects are registered from the state being entered
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= S_FETCH;
            wait_cnt   <= '0;
            Trap       <= 1'b0;
            TrapCause  <= 2'b00;
            ALUSrcA    <= 2'b00;
            ALUSrcB    <= 2'b10;
            ResultSrc  <= 2'b10;
            AdrSrc     <= 1'b0;
            ALUControl <= ALU_ADD;
            mreq_q     <= 1'b1;
        end else begin
            state      <= nxt;
            wait_cnt   <= (waiting && !MemReady && (nxt == state)) ? wait_cnt + 1'b1 : '0;
            Trap       <= (nxt == S_FAULT);
            TrapCause  <= nxt_cause;
            ALUSrcA    <= 2'b00;
            ALUSrcB    <= 2'b00;
            ResultSrc  <= 2'b00;
            AdrSrc     <= 1'b0;
            ALUControl <= ALU_ADD;
            mreq_q     <= 1'b0;
            case (nxt)
                S_FETCH: begin
                    ALUSrcB   <= 2'b10;
                    ResultSrc <= 2'b10;
                    mreq_q    <= 1'b1;
                end
                S_DECODE: begin
                    ALUSrcA <= 2'b01;
                    ALUSrcB <= 2'b01;
                end
                S_MEMADR: begin
                    ALUSrcA <= 2'b10;
                    ALUSrcB <= 2'b01;
                end
                S_MEMREAD, S_MEMWRITE: begin
                    AdrSrc <= 1'b1;
                    mreq_q <= 1'b1;
                end
                S_MEMWB: ResultSrc <= 2'b01;
                S_EXECR: begin
                    ALUSrcA    <= 2'b10;
                    ALUControl <= alu_dec;
                end
                S_EXECI: begin
                    ALUSrcA    <= 2'b10;
                    ALUSrcB    <= 2'b01;
                    ALUControl <= alu_dec;
                end
                S_LUI: begin
                    ALUSrcB    <= 2'b01;
                    ALUControl <= ALU_PASSB;
                end
                S_AUIPC: begin
                    ALUSrcA <= 2'b01;
                    ALUSrcB <= 2'b01;
                end
                S_BRANCH: begin
                    ALUSrcA    <= 2'b10;
                    ALUControl <= ALU_SUB;
                end
                S_JAL, S_JALR_LINK: begin
                    ALUSrcA <= 2'b01;
                    ALUSrcB <= 2'b10;
                end
                S_JALR_TGT: begin
                    ALUSrcA   <= 2'b10;
                    ALUSrcB   <= 2'b01;
                    ResultSrc <= 2'b10;
                end
                default: ;
            endcase
        end
    end

    // Enables are suppressed during the reset cycle regardless of state
    assign IRWrite  = reset && (state == S_FETCH) && MemReady;
    assign PCWrite  = reset && (((state == S_FETCH) && MemReady) ||
                                ((state == S_BRANCH) && br_legal && br_taken) ||
                                (state == S_JAL) || (state == S_JALR_TGT));
    assign RegWrite = reset && ((state == S_MEMWB) || (state == S_ALUWB));
    assign MemWrite = reset && (state == S_MEMWRITE) && MemReady;
    assign MemReq   = reset && mreq_q;

endmodule

// File: tb/tb_mc_controller_hs.sv
// tb/tb_mc_controller_hs.sv - randomized scoreboard bench for mc_controller_hs
module tb_mc_controller_hs;
    localparam int TO = 4;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BAD   = 7'b1111111;

    localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_AND = 4'd2, A_OR = 4'd3;
    localparam logic [3:0] A_XOR = 4'd4, A_SLT = 4'd5, A_SLL = 4'd6, A_SRL = 4'd7;
    localparam logic [3:0] A_SRA = 4'd8, A_SLTU = 4'd9, A_PASSB = 4'd10;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5, N, Z, C, V, MemReady;
    logic [2:0] ImmSrc;
    logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, TrapCause;
    logic       AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite, MemReq, Trap;
    logic [3:0] ALUControl;

    always #5 clk = ~clk;

    mc_controller_hs #(.TIMEOUT_CYCLES(TO), .CNT_W(3)) dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .N(N), .Z(Z), .C(C), .V(V), .MemReady(MemReady),
        .ImmSrc(ImmSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
        .AdrSrc(AdrSrc), .ALUControl(ALUControl), .IRWrite(IRWrite), .PCWrite(PCWrite),
        .RegWrite(RegWrite), .MemWrite(MemWrite), .MemReq(MemReq), .Trap(Trap),
        .TrapCause(TrapCause)
    );

    typedef struct packed {
        logic [2:0] imm;
        logic [1:0] a;
        logic [1:0] b;
        logic [1:0] rs;
        logic       adr;
        logic [3:0] alu;
        logic       irw;
        logic       pcw;
        logic       rw;
        logic       mw;
        logic       mreq;
        logic       trap;
        logic [1:0] cause;
    } ctl_t;

    typedef struct {
        ctl_t  e;
        ctl_t  m;
        string name;
    } item_t;

    item_t      q[$];
    int         checks = 0;
    int         errors = 0;
    ctl_t       act, e, m;
    logic       exp_trap = 1'b0;
    logic [1:0] exp_cause = 2'b00;

    assign act = {ImmSrc, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, ALUControl,
                  IRWrite, PCWrite, RegWrite, MemWrite, MemReq, Trap, TrapCause};

    always @(negedge clk) begin : monitor
        item_t it;
        if (q.size() != 0) begin
            it = q.pop_front();
            checks++;
            if (((act ^ it.e) & it.m) != '0) begin
                errors++;
                $display("FAIL %s: got %h required %h (care mask %h)", it.name, act, it.e & it.m, it.m);
            end
        end
    end

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [2:0] imm_of(input logic [6:0] o);
        case (o)
            OP_STORE:         return 3'b001;
            OP_BR:            return 3'b010;
            OP_JAL:           return 3'b011;
            OP_LUI, OP_AUIPC: return 3'b100;
            default:          return 3'b000;
        endcase
    endfunction

    function automatic logic [3:0] alu_of(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        case (f3)
            3'd0:    return (o == OP_R && f7) ? A_SUB : A_ADD;
            3'd1:    return A_SLL;
            3'd2:    return A_SLT;
            3'd3:    return A_SLTU;
            3'd4:    return A_XOR;
            3'd5:    return f7 ? A_SRA : A_SRL;
            3'd6:    return A_OR;
            default: return A_AND;
        endcase
    endfunction

    function automatic logic taken_of(input logic [2:0] f3, input logic [3:0] nzcv);
        logic lt;
        lt = nzcv[3] ^ nzcv[0];
        case (f3)
            3'd0:    return nzcv[2];
            3'd1:    return !nzcv[2];
            3'd4:    return lt;
            3'd5:    return !lt;
            3'd6:    return !nzcv[1];
            3'd7:    return nzcv[1];
            default: return 1'b0;
        endcase
    endfunction

    task automatic begin_step();
        {N, Z, C, V} = 4'($urandom);
        e = '0;
        m = '0;
        e.imm = imm_of(op);
        m.imm = 3'b111;
        m.irw = 1'b1; m.pcw = 1'b1; m.rw = 1'b1; m.mw = 1'b1; m.mreq = 1'b1;
        m.trap = 1'b1; m.cause = 2'b11;
        e.trap = exp_trap;
        e.cause = exp_cause;
    endtask

    // care bits: {a, b, rs, adr, alu}
    task automatic set_sel(input logic [1:0] a, input logic [1:0] b, input logic [1:0] rs,
                           input logic adr, input logic [3:0] alu, input logic [4:0] care);
        e.a = a;     m.a = {2{care[4]}};
        e.b = b;     m.b = {2{care[3]}};
        e.rs = rs;   m.rs = {2{care[2]}};
        e.adr = adr; m.adr = care[1];
        e.alu = alu; m.alu = {4{care[0]}};
    endtask

    task automatic step(input string name, input logic rdy);
        item_t it;
        MemReady = rdy;
        it.e = e;
        it.m = m;
        it.name = name;
        q.push_back(it);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        e = '0;
        m = '0;
        m.irw = 1'b1; m.pcw = 1'b1; m.rw = 1'b1; m.mw = 1'b1;
        step("reset_cycle", rb());
        reset = 1'b1;
        exp_trap = 1'b0;
        exp_cause = 2'b00;
    endtask

    task automatic fetch_word();
        begin_step();
        set_sel(2'b00, 2'b10, 2'b10, 1'b0, A_ADD, 5'b11111);
        e.mreq = 1'b1;
    endtask

    task automatic fetch(input int waits);
        for (int i = 0; i < waits; i++) begin
            fetch_word();
            step("fetch_wait", 1'b0);
        end
        fetch_word();
        e.irw = 1'b1;
        e.pcw = 1'b1;
        step("fetch_done", 1'b1);
    endtask

    task automatic fault_cycles(input int n, input logic [1:0] cause);
        exp_trap = 1'b1;
        exp_cause = cause;
        for (int i = 0; i < n; i++) begin
            begin_step();
            set_sel(2'b00, 2'b00, 2'b00, 1'b0, A_ADD, 5'b11111);
            step("fault", rb());
        end
    endtask

    task automatic mem_access(input int waits, input logic is_store);
        for (int i = 0; i <= waits; i++) begin
            begin_step();
            set_sel(2'b00, 2'b00, 2'b00, 1'b1, A_ADD, 5'b00110);
            e.mreq = 1'b1;
            e.mw = is_store && (i == waits);
            step(is_store ? "memwrite" : "memread", i == waits);
        end
    endtask

    task automatic aluwb();
        begin_step();
        set_sel(2'b00, 2'b00, 2'b00, 1'b0, A_ADD, 5'b00100);
        e.rw = 1'b1;
        step("aluwb", rb());
    endtask

    task automatic do_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                            input int fw, input int mwt, input logic [3:0] fl);
        op = o;
        funct3 = f3;
        funct7b5 = f7;
        fetch(fw);
        begin_step();
        set_sel(2'b01, 2'b01, 2'b00, 1'b0, A_ADD, 5'b11001);
        step("decode", rb());
        case (o)
            OP_LOAD, OP_STORE: begin
                begin_step();
                set_sel(2'b10, 2'b01, 2'b00, 1'b0, A_ADD, 5'b11001);
                step("memadr", rb());
                mem_access(mwt, o == OP_STORE);
                if (o == OP_LOAD) begin
                    begin_step();
                    set_sel(2'b00, 2'b00, 2'b01, 1'b0, A_ADD, 5'b00100);
                    e.rw = 1'b1;
                    step("memwb", rb());
                end
            end
            OP_R, OP_I: begin
                begin_step();
                set_sel(2'b10, (o == OP_R) ? 2'b00 : 2'b01, 2'b00, 1'b0, alu_of(o, f3, f7), 5'b11001);
                step(o == OP_R ? "execr" : "execi", rb());
                aluwb();
            end
            OP_LUI: begin
                begin_step();
                set_sel(2'b00, 2'b01, 2'b00, 1'b0, A_PASSB, 5'b01001);
                step("lui", rb());
                aluwb();
            end
            OP_AUIPC: begin
                begin_step();
                set_sel(2'b01, 2'b01, 2'b00, 1'b0, A_ADD, 5'b11001);
                step("auipc", rb());
                aluwb();
            end
            OP_BR: begin
                begin_step();
                {N, Z, C, V} = fl;
                set_sel(2'b10, 2'b00, 2'b00, 1'b0, A_SUB, 5'b11101);
                e.pcw = taken_of(f3, fl);
                step("branch", rb());
                if (f3 == 3'd2 || f3 == 3'd3) begin
                    fault_cycles(3, 2'b10);
                    do_reset();
                end
            end
            OP_JAL: begin
                begin_step();
                set_sel(2'b01, 2'b10, 2'b00, 1'b0, A_ADD, 5'b11101);
                e.pcw = 1'b1;
                step("jal", rb());
                aluwb();
            end
            OP_JALR: begin
                begin_step();
                set_sel(2'b10, 2'b01, 2'b10, 1'b0, A_ADD, 5'b11101);
                e.pcw = 1'b1;
                step("jalr_tgt", rb());
                begin_step();
                set_sel(2'b01, 2'b10, 2'b00, 1'b0, A_ADD, 5'b11001);
                step("jalr_link", rb());
                aluwb();
            end
            default: begin
                fault_cycles(3, 2'b01);
                do_reset();
            end
        endcase
    endtask

    logic [6:0] legal_ops [9];
    logic [6:0] ro;
    logic [2:0] rf3;

    initial begin
        legal_ops = '{OP_LOAD, OP_STORE, OP_R, OP_I, OP_LUI, OP_AUIPC, OP_BR, OP_JAL, OP_JALR};
        reset = 1'b0;
        op = OP_R;
        funct3 = 3'd0;
        funct7b5 = 1'b0;
        {N, Z, C, V} = 4'b0000;
        MemReady = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        do_instr(OP_R, 3'd0, 1'b0, 0, 0, 4'b0000);
        do_instr(OP_LOAD, 3'd2, 1'b0, 3, 2, 4'b0000);
        do_instr(OP_BR, 3'd1, 1'b0, 0, 0, 4'b0000);
        do_instr(OP_BR, 3'd4, 1'b0, 0, 0, 4'b1000);
        do_instr(OP_BR, 3'd7, 1'b0, 0, 0, 4'b0000);
        do_instr(OP_BR, 3'd2, 1'b0, 0, 0, 4'b0100);
        do_instr(OP_JALR, 3'd0, 1'b0, 1, 0, 4'b0000);
        do_instr(OP_STORE, 3'd2, 1'b0, 0, 1, 4'b0000);
        do_instr(OP_BAD, 3'd0, 1'b0, 0, 0, 4'b0000);
        do_instr(OP_I, 3'd0, 1'b1, 0, 0, 4'b0000);
        do_instr(OP_R, 3'd5, 1'b1, 2, 0, 4'b0000);

        // fetch stalled past the timeout window
        op = OP_R;
        for (int i = 0; i < TO; i++) begin
            fetch_word();
            step("fetch_stall", 1'b0);
        end
        fault_cycles(3, 2'b11);
        do_reset();

        // MemReady on the last allowed cycle completes normally
        do_instr(OP_AUIPC, 3'd0, 1'b0, TO - 1, 0, 4'b0000);

        // reset while a load waits on memory
        op = OP_LOAD;
        fetch(0);
        begin_step();
        set_sel(2'b01, 2'b01, 2'b00, 1'b0, A_ADD, 5'b11001);
        step("decode", rb());
        begin_step();
        set_sel(2'b10, 2'b01, 2'b00, 1'b0, A_ADD, 5'b11001);
        step("memadr", rb());
        begin_step();
        set_sel(2'b00, 2'b00, 2'b00, 1'b1, A_ADD, 5'b00110);
        e.mreq = 1'b1;
        step("memread_wait", 1'b0);
        do_reset();

        for (int n = 0; n < 60; n++) begin
            ro = legal_ops[$urandom_range(0, 8)];
            rf3 = 3'($urandom);
            if (ro == OP_BR && (rf3 == 3'd2 || rf3 == 3'd3)) rf3 = rf3 | 3'b100;
            do_instr(ro, rf3, rb(), $urandom_range(0, TO - 1), $urandom_range(0, TO - 1), 4'($urandom));
        end

        for (int i = 0; i < 5 && q.size() != 0; i++) @(posedge clk);
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d items left, required 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mc_controller_hs.md
Name: mc_controller_hs

Overview:
- Parametrised successor to the multicycle RV32I controller: same datapath control encodings, plus a memory request/ready handshake with wait states and a bus timeout.
- Decodes the full branch set (beq/bne/blt/bge/bltu/bgeu) and jalr/lui/auipc.
- Traps on illegal opcodes and illegal branch funct3.
- Sits between the instruction register/flag outputs and the multicycle datapath and memory.

Parameters:
TIMEOUT_CYCLES, 16, stalled cycles (MemReq=1, MemReady=0) before a timeout trap; 0 disables the timeout.
CNT_W, 5, width of the wait counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-low reset
op  in  7  instruction opcode
funct3  in  3  instruction funct3
funct7b5  in  1  instruction bit 30
N, Z, C, V  in  1 each  ALU flags of the current cycle
MemReady  in  1  memory completes the current access this cycle
ImmSrc  out  3  000 I, 001 S, 010 B, 011 J, 100 U
ALUSrcA  out  2  00 PC, 01 OldPC, 10 register A
ALUSrcB  out  2  00 register WD, 01 ImmExt, 10 constant 4
ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult
AdrSrc  out  1  0 PC, 1 Result
ALUControl  out  4  0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 slt, 0110 sll, 0111 srl, 1000 sra, 1001 sltu, 1010 passB
IRWrite, PCWrite, RegWrite, MemWrite, MemReq  out  1 each  enables / memory request
Trap  out  1  sticky fault indicator
TrapCause  out  2  01 illegal opcode, 10 illegal branch funct3, 11 memory timeout

Behaviour:
- Reset (reset=0 at a clock edge): state=FETCH, wait counter=0, Trap=0, TrapCause=00. Outputs are Moore per state except the handshake qualifiers below.
- Write enables are 0 in every state not listed as asserting them.
- FETCH:
  - Drives MemReq=1, AdrSrc=0, A=00, B=10, ALUOp add, ResultSrc=10.
  - IRWrite=1 and PCWrite=1 only in the cycle MemReady=1, which also transitions to DECODE. Otherwise the FSM stays in FETCH.
- DECODE: A=01, B=01, add (ALUOut=OldPC+imm). Next state by op:
  - 0000011/0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 0110111 → LUI
  - 0010111 → AUIPC
  - 1100011 → BRANCH
  - 1101111 → JAL
  - 1100111 → JALR_TGT
  - any other op → FAULT, cause 01
- MEMADR: A=10, B=01, add. Next state MEMREAD for loads, MEMWRITE for stores.
- MEMREAD: MemReq=1, AdrSrc=1, ResultSrc=00. Holds until MemReady=1, then MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1. Next state FETCH.
- MEMWRITE: MemReq=1, AdrSrc=1, ResultSrc=00. MemWrite=1 only while MemReady=1; transitions to FETCH on that cycle.
- EXECR / EXECI:
  - Operands A=10 with B=00 (EXECR) or B=01 (EXECI).
  - ALUControl from funct3: 000 add, or sub when op[5]&funct7b5; 001 sll; 010 slt; 011 sltu; 100 xor; 101 srl, or sra when funct7b5; 110 or; 111 and.
  - Next state ALUWB.
- LUI: B=01, passB. Next state ALUWB.
- AUIPC: A=01, B=01, add. Next state ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1. Next state FETCH.
- BRANCH:
  - A=10, B=00, sub, ResultSrc=00.
  - Taken condition by funct3: 000 Z; 001 !Z; 100 N^V; 101 !(N^V); 110 !C; 111 C.
  - PCWrite=taken. Next state FETCH.
  - funct3 010/011 → FAULT, cause 10, with PCWrite=0.
- JAL: A=01, B=10, add, ResultSrc=00, PCWrite=1. Next state ALUWB.
- JALR_TGT: A=10, B=01, add, ResultSrc=10, PCWrite=1. Next state JALR_LINK.
- JALR_LINK: A=01, B=10, add (ALUOut=OldPC+4). Next state ALUWB.
- Wait counter:
  - Increments each cycle in FETCH, MEMREAD or MEMWRITE with MemReady=0.
  - Clears on MemReady=1 or when leaving those states.
  - When TIMEOUT_CYCLES≠0 and the counter reaches TIMEOUT_CYCLES-1 with MemReady still 0, the next state is FAULT, cause 11.
  - MemReady=1 in that same cycle wins: normal completion, no trap.
- FAULT:
  - Absorbing; left only via reset.
  - Trap=1, TrapCause held.
  - All write enables and MemReq are 0. Mux selects = 00, ALUControl = add.
- ImmSrc is combinational from op in every state: loads/I-type/jalr I; store S; branch B; jal J; lui/auipc U; else 000.
- Reset mid-access (any state, including during a wait): FETCH next cycle, counter cleared, no enable asserted in the reset cycle.

Test Plan:
- add (op 0110011, f3 000, f7b5 0), MemReady tied 1 → FETCH, DECODE, EXECR (ALUControl 0000), ALUWB (RegWrite=1); 4 cycles, IRWrite/PCWrite pulse once.
- lw with MemReady low 3 cycles in FETCH and 2 cycles in MEMREAD → IRWrite only on the 4th FETCH cycle; RegWrite in MEMWB after MemReady; total 10 cycles.
- Branches with f3 001 (Z=0), 100 (N=1, V=0), 111 (C=0) → PCWrite=1, 1, 0 respectively; f3 010 → Trap=1, TrapCause=10, PCWrite=0.
- TIMEOUT_CYCLES=4, MemReady stuck 0 in FETCH → FAULT after 4 FETCH cycles, Trap=1, TrapCause=11; MemReady=1 on the 4th cycle instead → DECODE, no trap.
- op 1111111 → FAULT, cause 01; FAULT persists until reset=0 at a clock edge → FETCH, Trap=0.
- jalr → JALR_TGT (PCWrite=1, A=10, B=01), JALR_LINK (A=01, B=10), ALUWB (RegWrite=1); sw with MemReady=1 on the 2nd MEMWRITE cycle → exactly one MemWrite pulse.
